// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared defaults and count-width helper for the synchronous FIFO
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - DEPTH x DATA_W register array, synchronous write, asynchronous read
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; the control logic discards contents via the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parameterised synchronous FIFO with occupancy flags and sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         buf_in,
  input  logic                      rd_en,
  input  logic                      clr_err,
  output logic [DATA_W-1:0]         buf_out,
  output logic                      rd_valid,
  output logic                      buf_empty,
  output logic                      buf_full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic [cnt_w(DEPTH)-1:0]   fifo_counter,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_ok;
  logic              rd_ok;
  logic              ovf_evt;
  logic              udf_evt;

  assign buf_empty    = (fifo_counter == '0);
  assign buf_full     = (fifo_counter == CW'(DEPTH));
  assign almost_empty = (fifo_counter <= CW'(AEMPTY_TH));
  assign almost_full  = (fifo_counter >= CW'(AFULL_TH));

  assign rd_ok   = rd_en & ~buf_empty;
  assign wr_ok   = wr_en & (~buf_full | rd_ok);
  assign ovf_evt = wr_en & buf_full & ~rd_ok;
  // A read on an empty FIFO paired with a write is not an error: the write alone proceeds.
  assign udf_evt = rd_en & buf_empty & ~wr_en;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (buf_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   fifo_counter <= fifo_counter + CW'(1);
        2'b01:   fifo_counter <= fifo_counter - CW'(1);
        default: fifo_counter <= fifo_counter;
      endcase
      // A new error in the clear cycle wins over the clear.
      overflow  <= ovf_evt | (overflow  & ~clr_err);
      underflow <= udf_evt | (underflow & ~clr_err);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign buf_out  = buf_empty ? '0 : mem_rdata;
  assign rd_valid = ~buf_empty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_out  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        buf_out <= mem_rdata;
      end
    end
  end
`endif

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, 4..256.
REQ-003 Parameter AFULL_TH, default DEPTH-2, almost_full threshold in entries.
REQ-004 Parameter AEMPTY_TH, default 2, almost_empty threshold in entries.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 wr_en  in  1  write request.
REQ-008 buf_in  in  DATA_W  write data.
REQ-009 rd_en  in  1  read request (acknowledge in FWFT mode).
REQ-010 clr_err  in  1  synchronous clear of the sticky error flags.
REQ-011 buf_out  out  DATA_W  read data.
REQ-012 rd_valid  out  1  buf_out holds a valid popped word.
REQ-013 buf_empty / buf_full  out  1 each  occupancy is 0 / occupancy is DEPTH.
REQ-014 almost_empty / almost_full  out  1 each  fifo_counter<=AEMPTY_TH / fifo_counter>=AFULL_TH.
REQ-015 fifo_counter  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow / underflow  out  1 each  sticky error flags.

Function
REQ-017 A write is accepted when wr_en=1 and (buf_full=0 or a read is accepted in the same cycle); buf_in is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-018 A read is accepted when rd_en=1 and buf_empty=0; rd_ptr increments modulo DEPTH.
REQ-019 fifo_counter updates in the next cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 Simultaneous read and write when full: both are accepted and the count stays at DEPTH; when empty, only the write is accepted.
REQ-021 Pointer wrap from DEPTH-1 to 0 is seamless, and data order is preserved across the wrap.
REQ-022 All flags derive from the registered fifo_counter and are valid in the same cycle as the count.
REQ-023 A rejected write (wr_en=1 while full with no read) sets overflow, and the data is dropped.
REQ-024 A rejected read (rd_en=1 while empty) sets underflow; buf_out holds its value and rd_valid=0.
REQ-025 overflow and underflow stay set until clr_err=1 or reset; if clr_err coincides with a new error, the flag remains set.

Reset
REQ-026 Reset drives buf_out=0, rd_valid=0, buf_empty=1, buf_full=0, almost_empty=1, almost_full=0, fifo_counter=0, overflow=0, underflow=0, and both pointers to 0.
REQ-027 Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge; storage array contents are not reset.

Configuration
REQ-028 Macro SYNC_FIFO_FWFT_EN selects the read mode.
REQ-029 Without the macro (standard mode): an accepted read updates buf_out with the head word and sets rd_valid=1 one cycle later (1-cycle latency); rd_valid=0 after a cycle with no accepted read.
REQ-030 With the macro (first-word-fall-through): buf_out presents the head word whenever buf_empty=0 and rd_valid=~buf_empty; rd_en pops the word; the first write into an empty FIFO appears on buf_out the cycle after the write.

Structure
REQ-031 Package sync_fifo_pkg holds the default DATA_W/DEPTH constants and the count-width function (clog2(DEPTH)+1).
REQ-032 Storage is a sub-module sync_fifo_mem: DEPTH x DATA_W register array with synchronous write and asynchronous read by address; control, pointers and flags stay in sync_fifo_param.

Verification (DEPTH=16, DATA_W=8, AFULL_TH=14, AEMPTY_TH=2)
REQ-033 Reset asserted mid-traffic between clock edges -> all outputs go to their reset values immediately; the next read is rejected with underflow=1.
REQ-034 Write 0x01..0x10, then write 0xFF once -> buf_full=1, fifo_counter=16, almost_full=1 from count 14, overflow=1; a subsequent read of 16 words returns 0x01..0x10 in order.
REQ-035 Read from empty, then clr_err=1 -> underflow=1 and rd_valid=0; underflow=0 after the clear cycle.
REQ-036 Write 10 and read 10, repeated 3 times -> pointers wrap and the output order is exact; fifo_counter ends at 0 and buf_empty=1.
REQ-037 Simultaneous wr_en=rd_en=1 at count 16 and at count 0 -> count stays 16 (both accepted); count becomes 1 (write only) with no underflow.
REQ-038 Run REQ-034 twice, once with SYNC_FIFO_FWFT_EN and once without -> first word 0x01 appears one cycle earlier relative to rd_en in FWFT mode.
